// File: rtl/cfu_mac_initiator.sv
// cfu_mac_initiator: command master for the CFU MAC unit; issues offsets, clear, then one ADD per stream word.
// Optional response watchdog is compiled in with `define CFU_INIT_TIMEOUT_EN.
module cfu_mac_initiator #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [8:0]       in_off,
    input  logic [8:0]       flt_off,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             error,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_act,
    input  logic [31:0]      s_wgt,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_payload_outputs_0
);

    typedef enum logic [2:0] {IDLE, IOFF, FOFF, CLR, MAC, WAIT, DONE} state_t;

    localparam logic [9:0] FID_ADD   = 10'd0;
    localparam logic [9:0] FID_RESET = 10'd1;
    localparam logic [9:0] FID_IOFF  = 10'd2;
    localparam logic [9:0] FID_FOFF  = 10'd3;

    state_t           state_q, state_d, phase_q, phase_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [9:0]       fid_q, fid_d;
    logic [31:0]      in0_q, in0_d, in1_q, in1_d;
    logic [31:0]      result_q, result_d;
    logic [8:0]       foff_q, foff_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             cmd_hs, rsp_hs, s_hs;

`ifdef CFU_INIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             error_q, error_d;
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    function automatic logic [31:0] sext_off(input logic signed [8:0] v);
        return 32'(v);
    endfunction

    assign cmd_hs  = cmd_valid_q && cmd_ready;
    assign rsp_hs  = (state_q == WAIT) && rsp_valid;
    assign s_ready = (state_q == MAC) && !cmd_valid_q;
    assign s_hs    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cmd_valid_d = cmd_valid_q;
        fid_d       = fid_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        result_d    = result_q;
        foff_d      = foff_q;
        cnt_d       = cnt_q;
`ifdef CFU_INIT_TIMEOUT_EN
        tmo_d       = tmo_q;
        error_d     = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    foff_d      = flt_off;
                    cnt_d       = len;
                    fid_d       = FID_IOFF;
                    in0_d       = sext_off(in_off);
                    in1_d       = '0;
                    cmd_valid_d = 1'b1;
                    state_d     = IOFF;
                end
            end
            IOFF, FOFF, CLR: begin
                if (cmd_hs) begin
                    cmd_valid_d = 1'b0;
                    phase_d     = state_q;
                    state_d     = WAIT;
                end
            end
            MAC: begin
                if (cmd_hs) begin
                    cmd_valid_d = 1'b0;
                    phase_d     = MAC;
                    state_d     = WAIT;
                end else if (s_hs) begin
                    fid_d       = FID_ADD;
                    in0_d       = s_act;
                    in1_d       = s_wgt;
                    cmd_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    result_d = rsp_payload_outputs_0;
                    case (phase_q)
                        IOFF: begin
                            fid_d       = FID_FOFF;
                            in0_d       = sext_off(foff_q);
                            in1_d       = '0;
                            cmd_valid_d = 1'b1;
                            state_d     = FOFF;
                        end
                        FOFF: begin
                            fid_d       = FID_RESET;
                            in0_d       = '0;
                            in1_d       = '0;
                            cmd_valid_d = 1'b1;
                            state_d     = CLR;
                        end
                        CLR:     state_d = (cnt_q != '0) ? MAC : DONE;
                        MAC: begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = (cnt_q == LEN_W'(1)) ? DONE : MAC;
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef CFU_INIT_TIMEOUT_EN
        if ((state_q == IDLE) && start) begin
            error_d = 1'b0;
        end
        // Counter restarts on any handshake; expiry aborts the job through DONE.
        if (cmd_hs || rsp_hs) begin
            tmo_d = '0;
        end else if ((cmd_valid_q && !cmd_ready) || (state_q == WAIT)) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d       = '0;
                cmd_valid_d = 1'b0;
                error_d     = 1'b1;
                result_d    = '0;
                state_d     = DONE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            fid_q       <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            result_q    <= '0;
            foff_q      <= '0;
            cnt_q       <= '0;
`ifdef CFU_INIT_TIMEOUT_EN
            tmo_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_valid_q <= cmd_valid_d;
            fid_q       <= fid_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            result_q    <= result_d;
            foff_q      <= foff_d;
            cnt_q       <= cnt_d;
`ifdef CFU_INIT_TIMEOUT_EN
            tmo_q       <= tmo_d;
            error_q     <= error_d;
`endif
        end
    end

    assign busy                    = (state_q != IDLE) && (state_q != DONE);
    assign done                    = (state_q == DONE);
    assign rsp_ready               = (state_q == WAIT);
    assign cmd_valid               = cmd_valid_q;
    assign cmd_payload_function_id = fid_q;
    assign cmd_payload_inputs_0    = in0_q;
    assign cmd_payload_inputs_1    = in1_q;
    assign result                  = result_q;
`ifdef CFU_INIT_TIMEOUT_EN
    assign error                   = error_q;
`else
    assign error                   = 1'b0;
`endif

endmodule

// File: doc/cfu_mac_initiator.md
# cfu_mac_initiator

Command-issuing master for the CFU MAC accelerator bus: it drives the cmd/rsp handshake that the CFU MAC unit responds to. On a host `start` pulse it sequences SET_INPUT_OFFSET, SET_FILTER_OFFSET and RESET, then one ADD per packed int8 word pair pulled from an activation/weight stream. It returns the final accumulator value to the host. It sits between the layer-control logic and the CFU and keeps exactly one command outstanding.

## Interface
- `LEN_W`, 16: width of the MAC-word count.
- `TIMEOUT_CYCLES`, 255: response watchdog limit, used only with the macro under Configuration.

- `clk`  in  1  single clock, all logic on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `in_off`  in  9  signed input offset, latched on start.
- `flt_off`  in  9  signed filter offset, latched on start.
- `len`  in  LEN_W  number of ADD commands, latched on start.
- `busy`  out  1  high from the cycle after start until done.
- `done`  out  1  one-cycle pulse at job end.
- `result`  out  32  final accumulator, held until the next start.
- `error`  out  1  watchdog abort flag, cleared on start.
- `s_valid`/`s_ready`  in/out  1  operand stream handshake.
- `s_act`, `s_wgt`  in  32  four packed int8 activations / weights.
- `cmd_valid`  out  1; `cmd_ready`  in  1.
- `cmd_payload_function_id`  out  10: 0=ADD, 1=RESET, 2=SET_INPUT_OFFSET, 3=SET_FILTER_OFFSET.
- `cmd_payload_inputs_0`, `cmd_payload_inputs_1`  out  32.
- `rsp_valid`  in  1; `rsp_ready`  out  1; `rsp_payload_outputs_0`  in  32.

## Operation
- States: IDLE, IOFF, FOFF, CLR, MAC, WAIT, DONE.
- IDLE -> IOFF on `start`.
- IOFF, FOFF and CLR each present one command, then go to WAIT. WAIT returns to the next issue state on the response handshake.
- After CLR, go to MAC if the latched len != 0, else go to DONE.
- MAC: `s_ready`=1 while `cmd_valid`=0.
  - On an `s_valid&&s_ready` handshake, register `s_act`->inputs_0 and `s_wgt`->inputs_1 with fid=0, then assert `cmd_valid`.
  - After the response, decrement the remaining count. At 0 go to DONE, else return to MAC.
- IOFF/FOFF payload: inputs_0 = sign-extension of the offset to 32 bits; inputs_1 = 0. CLR payload: both inputs = 0.
- Each response handshake (`rsp_valid&&rsp_ready`) loads `rsp_payload_outputs_0` into `result`.
  - len=0: result equals the CLR response (0 from a correct CFU).
- DONE: pulse `done` for one cycle, then go to IDLE.
- A `start` while busy is ignored. `len` and the offsets are not re-sampled mid-job.
- Reset values: `cmd_valid`, `rsp_ready`, `s_ready`, `busy`, `done` and `error` = 0; `result` and all payload outputs = 0; state=IDLE.
- Reset mid-job aborts immediately with no drain. The CFU must be reset in the same domain.

## Timing
- `start` in cycle N -> `cmd_valid` in N+1 with fid=2.
- Payload and fid are registered and held stable while `cmd_valid && !cmd_ready`. `cmd_valid` drops in the cycle after the accept.
- `rsp_ready`=1 exactly in WAIT. A response arriving in the same cycle as the accept is not consumed until WAIT.
- Stream word accepted in cycle M -> `cmd_valid` in M+1.
- With `cmd_ready` and `rsp_valid` both one cycle after each accept, each command costs 3 cycles.
- `done` rises the cycle after the final response handshake. `result` is valid in the same cycle as `done`.
- The length counter is LEN_W bits wide; len = 2^LEN_W-1 has no wrap.

## Configuration
- `CFU_INIT_TIMEOUT_EN` defined: a counter runs while `cmd_valid && !cmd_ready` or while in WAIT, and resets on every handshake.
  - On reaching `TIMEOUT_CYCLES`: deassert `cmd_valid`/`rsp_ready`, set `error`=1, set `result`=0, pulse `done`, go to IDLE.
- Undefined: no counter; `error` is tied to 0 and the block waits indefinitely.

## Test plan
- Basic job: offsets 0, len=1, act=0x01010101, wgt=0x02020202, CFU always ready -> fid sequence 2,3,1,0; `result`=8; `done` for one cycle; `busy` low afterwards.
- Offsets: in_off=1, flt_off=0, same data, len=1 -> IOFF inputs_0=0x00000001; `result`=16. Then flt_off=-1 -> inputs_0=0xFFFFFFFF.
- Multi-word and backpressure: len=3 of the basic pair; random `cmd_ready`/`rsp_valid` stalls and `s_valid` gaps -> `result`=24; payload stable during every stall; exactly 6 commands issued.
- len=0: no `s_ready` assertion; `done` after the CLR response; `result`=0.
- Reset mid-job: drop `reset_n` during the second MAC of len=3 -> all outputs 0 at once. A new start after release runs cleanly.
- Timeout (macro defined, TIMEOUT_CYCLES=8): hold `cmd_ready`=0 -> `cmd_valid` drops after 8 cycles; `error`=1, `done` pulses, `result`=0.
